// File: rtl/pong_pkg.sv
// Shared geometry, speed constants and game-state encoding for the pong
// engine and the VGA renderer.
package pong_pkg;
    localparam int POS_W   = 10;
    localparam int SCORE_W = 4;

    localparam int CANVAS_TOP    = 50;
    localparam int CANVAS_BOTTOM = 450;
    localparam int CANVAS_LEFT   = 50;
    localparam int CANVAS_RIGHT  = 600;
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_OFFSET = 20;
    localparam int PADDLE_HEIGHT = 50;
    localparam int PADDLE_WIDTH  = 10;
    localparam int BALL_SPEED    = 2;
    localparam int PADDLE_SPEED  = 3;
    localparam int SERVE_FRAMES  = 60;
    localparam int WIN_SCORE     = 7;

    localparam int SERVE_W = $clog2(SERVE_FRAMES);

    // One extra bit over the screen coordinates so +/- speed never wraps.
    typedef logic signed [POS_W:0] coord_t;

    localparam logic [POS_W-1:0] BALL_X_HOME =
        POS_W'((CANVAS_LEFT + CANVAS_RIGHT) / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] BALL_Y_HOME =
        POS_W'((CANVAS_TOP + CANVAS_BOTTOM) / 2 - BALL_SIZE / 2);
    localparam logic [POS_W-1:0] PADDLE_HOME =
        POS_W'((CANVAS_TOP + CANVAS_BOTTOM) / 2 - PADDLE_HEIGHT / 2);

    localparam coord_t PADDLE_MIN = coord_t'(CANVAS_TOP + 1);
    localparam coord_t PADDLE_MAX = coord_t'(CANVAS_BOTTOM - 1 - PADDLE_HEIGHT);

    // Inner faces of the paddles: the columns the ball collides with.
    localparam int LEFT_FACE  = CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH;
    localparam int RIGHT_FACE = CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        SCORED,
        GAME_OVER
    } game_state_t;

    function automatic coord_t to_coord(input logic [POS_W-1:0] v);
        return coord_t'({1'b0, v});
    endfunction
endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: button-driven vertical movement once per enabled frame,
// clamped to the playfield interior.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [POS_W-1:0] pos
);
    localparam coord_t C_SPEED = coord_t'(PADDLE_SPEED);

    coord_t cur;
    coord_t nxt;

    function automatic logic [POS_W-1:0] clamp_pos(input coord_t p);
        coord_t c;
        c = p;
        if (p < PADDLE_MIN) begin
            c = PADDLE_MIN;
        end else if (p > PADDLE_MAX) begin
            c = PADDLE_MAX;
        end
        return POS_W'(c);
    endfunction

    // Opposing buttons cancel out and hold the paddle.
    always_comb begin
        cur = to_coord(pos);
        nxt = cur;
        if (btn_up && !btn_down) begin
            nxt = cur - C_SPEED;
        end else if (btn_down && !btn_up) begin
            nxt = cur + C_SPEED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= PADDLE_HOME;
        end else if (en) begin
            pos <= clamp_pos(nxt);
        end
    end
endmodule

// File: rtl/pong_game_engine.sv
// Pong game-state producer: paddles, ball motion, collisions, scoring and
// the serve / play / scored / game-over sequencing.
module pong_game_engine
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               btn_left_up,
    input  logic               btn_left_down,
    input  logic               btn_right_up,
    input  logic               btn_right_down,
    output logic [POS_W-1:0]   ball_pos_x,
    output logic [POS_W-1:0]   ball_pos_y,
    output logic [POS_W-1:0]   paddle_left_pos,
    output logic [POS_W-1:0]   paddle_right_pos,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over
);
    localparam coord_t C_TOP    = coord_t'(CANVAS_TOP);
    localparam coord_t C_BOTTOM = coord_t'(CANVAS_BOTTOM);
    localparam coord_t C_LEFT   = coord_t'(CANVAS_LEFT);
    localparam coord_t C_RIGHT  = coord_t'(CANVAS_RIGHT);
    localparam coord_t C_BALL   = coord_t'(BALL_SIZE);
    localparam coord_t C_PH     = coord_t'(PADDLE_HEIGHT);
    localparam coord_t C_SPEED  = coord_t'(BALL_SPEED);
    localparam coord_t C_LFACE  = coord_t'(LEFT_FACE);
    localparam coord_t C_RFACE  = coord_t'(RIGHT_FACE);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

    game_state_t        state_q, state_d;
    logic [POS_W-1:0]   ball_x_q, ball_x_d;
    logic [POS_W-1:0]   ball_y_q, ball_y_d;
    logic               dir_right_q, dir_right_d;
    logic               dir_down_q, dir_down_d;
    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               scorer_right_q, scorer_right_d;
    logic               game_over_q, game_over_d;

    coord_t bx, by, nx, ny, pl, pr;
    logic   ov_l, ov_r, hit_l, hit_r;
    logic   paddle_en;
    logic [SCORE_W-1:0] score_inc;

    assign paddle_en = frame_tick && (state_q != GAME_OVER);

    pong_paddle_ctrl u_paddle_left (
        .clk      (clk),
        .reset    (reset),
        .en       (paddle_en),
        .btn_up   (btn_left_up),
        .btn_down (btn_left_down),
        .pos      (paddle_left_pos)
    );

    pong_paddle_ctrl u_paddle_right (
        .clk      (clk),
        .reset    (reset),
        .en       (paddle_en),
        .btn_up   (btn_right_up),
        .btn_down (btn_right_down),
        .pos      (paddle_right_pos)
    );

    // Collision terms use pre-update ball and paddle positions.
    always_comb begin
        bx    = to_coord(ball_x_q);
        by    = to_coord(ball_y_q);
        pl    = to_coord(paddle_left_pos);
        pr    = to_coord(paddle_right_pos);
        nx    = dir_right_q ? bx + C_SPEED : bx - C_SPEED;
        ny    = dir_down_q  ? by + C_SPEED : by - C_SPEED;
        ov_l  = (by + C_BALL >= pl) && (by <= pl + C_PH);
        ov_r  = (by + C_BALL >= pr) && (by <= pr + C_PH);
        hit_l = !dir_right_q && (bx > C_LFACE) && (nx <= C_LFACE) && ov_l;
        hit_r = dir_right_q && (bx + C_BALL < C_RFACE) &&
                (nx + C_BALL >= C_RFACE) && ov_r;
    end

    always_comb begin
        state_d        = state_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        dir_right_d    = dir_right_q;
        dir_down_d     = dir_down_q;
        serve_cnt_d    = serve_cnt_q;
        score_l_d      = score_l_q;
        score_r_d      = score_r_q;
        scorer_right_d = scorer_right_q;
        game_over_d    = game_over_q;
        score_inc      = scorer_right_q ? score_r_q + 1'b1 : score_l_q + 1'b1;

        case (state_q)
            SERVE: begin
                ball_x_d = BALL_X_HOME;
                ball_y_d = BALL_Y_HOME;
                if (frame_tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (!dir_down_q && ny <= C_TOP) begin
                        ball_y_d   = POS_W'(C_TOP + 1);
                        dir_down_d = 1'b1;
                    end else if (dir_down_q && ny + C_BALL >= C_BOTTOM) begin
                        ball_y_d   = POS_W'(C_BOTTOM - 1 - C_BALL);
                        dir_down_d = 1'b0;
                    end else begin
                        ball_y_d = POS_W'(ny);
                    end

                    if (hit_l) begin
                        ball_x_d    = POS_W'(C_LFACE + 1);
                        dir_right_d = 1'b1;
                    end else if (hit_r) begin
                        ball_x_d    = POS_W'(C_RFACE - 1 - C_BALL);
                        dir_right_d = 1'b0;
                    end else if (!dir_right_q && nx <= C_LEFT) begin
                        scorer_right_d = 1'b1;
                        state_d        = SCORED;
                    end else if (dir_right_q && nx + C_BALL >= C_RIGHT) begin
                        scorer_right_d = 1'b0;
                        state_d        = SCORED;
                    end else begin
                        ball_x_d = POS_W'(nx);
                    end
                end
            end
            SCORED: begin
                // The next serve heads toward the player who conceded.
                if (scorer_right_q) begin
                    score_r_d   = score_inc;
                    dir_right_d = 1'b0;
                end else begin
                    score_l_d   = score_inc;
                    dir_right_d = 1'b1;
                end
                ball_x_d = BALL_X_HOME;
                ball_y_d = BALL_Y_HOME;
                if (score_inc == SCORE_WIN) begin
                    state_d     = GAME_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = SERVE;
                end
            end
            GAME_OVER: begin
                ball_x_d = BALL_X_HOME;
                ball_y_d = BALL_Y_HOME;
                if (start) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    game_over_d = 1'b0;
                    serve_cnt_d = '0;
                    state_d     = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SERVE;
            ball_x_q       <= BALL_X_HOME;
            ball_y_q       <= BALL_Y_HOME;
            dir_right_q    <= 1'b1;
            dir_down_q     <= 1'b1;
            serve_cnt_q    <= '0;
            score_l_q      <= '0;
            score_r_q      <= '0;
            scorer_right_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            dir_right_q    <= dir_right_d;
            dir_down_q     <= dir_down_d;
            serve_cnt_q    <= serve_cnt_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            scorer_right_q <= scorer_right_d;
            game_over_q    <= game_over_d;
        end
    end

    assign ball_pos_x  = ball_x_q;
    assign ball_pos_y  = ball_y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: a scripted rally checked against
// hand-computed positions, then a full game to WIN_SCORE, restart and reset.
module tb_pong_game_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       btn_left_up = 1'b0;
    logic       btn_left_down = 1'b0;
    logic       btn_right_up = 1'b0;
    logic       btn_right_down = 1'b0;
    logic [9:0] ball_pos_x, ball_pos_y, paddle_left_pos, paddle_right_pos;
    logic [3:0] score_left, score_right;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_game_engine dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .start            (start),
        .btn_left_up      (btn_left_up),
        .btn_left_down    (btn_left_down),
        .btn_right_up     (btn_right_up),
        .btn_right_down   (btn_right_down),
        .ball_pos_x       (ball_pos_x),
        .ball_pos_y       (ball_pos_y),
        .paddle_left_pos  (paddle_left_pos),
        .paddle_right_pos (paddle_right_pos),
        .score_left       (score_left),
        .score_right      (score_right),
        .game_over        (game_over)
    );

    typedef struct {
        int   ticks;
        logic lu, ld, ru, rd;
        int   bx, by, pl, pr, sl, sr;
        logic go;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame tick plus an idle clock so a SCORED step has resolved.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int bx, input int by,
                             input int pl, input int pr, input int sl,
                             input int sr, input int go);
        check({tag, " ball_x"}, int'(ball_pos_x), bx);
        check({tag, " ball_y"}, int'(ball_pos_y), by);
        check({tag, " pad_l"}, int'(paddle_left_pos), pl);
        check({tag, " pad_r"}, int'(paddle_right_pos), pr);
        check({tag, " score_l"}, int'(score_left), sl);
        check({tag, " score_r"}, int'(score_right), sr);
        check({tag, " game_over"}, int'(game_over), go);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_sum, sum, hi, lo, pl0, pr0, sl0, sr0;

        // Rally script: ticks applied with given buttons, then expected state.
        vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b1, 320, 245, 225, 228, 0, 0, 1'b0};
        vecs[1]  = '{59,  1'b0, 1'b0, 1'b0, 1'b1, 320, 245, 225, 399, 0, 0, 1'b0};
        vecs[2]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 322, 247, 225, 399, 0, 0, 1'b0};
        vecs[3]  = '{118, 1'b0, 1'b0, 1'b0, 1'b0, 558, 397, 225, 399, 0, 0, 1'b0};
        vecs[4]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 559, 395, 225, 399, 0, 0, 1'b0};
        vecs[5]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 557, 393, 225, 399, 0, 0, 1'b0};
        vecs[6]  = '{20,  1'b1, 1'b0, 1'b0, 1'b0, 517, 353, 165, 399, 0, 0, 1'b0};
        vecs[7]  = '{5,   1'b1, 1'b1, 1'b1, 1'b1, 507, 343, 165, 399, 0, 0, 1'b0};
        vecs[8]  = '{146, 1'b0, 1'b0, 1'b0, 1'b0, 215, 51,  165, 399, 0, 0, 1'b0};
        vecs[9]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 213, 51,  165, 399, 0, 0, 1'b0};
        vecs[10] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 211, 53,  165, 399, 0, 0, 1'b0};
        vecs[11] = '{65,  1'b0, 1'b0, 1'b0, 1'b0, 81,  183, 165, 399, 0, 0, 1'b0};
        vecs[12] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 81,  185, 165, 399, 0, 0, 1'b0};
        vecs[13] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 83,  187, 165, 399, 0, 0, 1'b0};
        vecs[14] = '{253, 1'b0, 1'b0, 1'b0, 1'b0, 589, 187, 165, 399, 0, 0, 1'b0};
        vecs[15] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 320, 245, 165, 399, 1, 0, 1'b0};
        vecs[16] = '{60,  1'b1, 1'b0, 1'b0, 1'b1, 320, 245, 51,  399, 1, 0, 1'b0};
        vecs[17] = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 322, 243, 51,  399, 1, 0, 1'b0};

        repeat (2) @(negedge clk);
        check_all("reset", 320, 245, 225, 225, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            btn_left_up    = vecs[i].lu;
            btn_left_down  = vecs[i].ld;
            btn_right_up   = vecs[i].ru;
            btn_right_down = vecs[i].rd;
            repeat (vecs[i].ticks) do_tick();
            check_all($sformatf("row%0d", i), vecs[i].bx, vecs[i].by, vecs[i].pl,
                      vecs[i].pr, vecs[i].sl, vecs[i].sr, int'(vecs[i].go));
        end

        // Play to the end, steering both paddles away from the ball.
        prev_sum = int'(score_left) + int'(score_right);
        for (int t = 0; t < 20000 && !game_over; t++) begin
            btn_left_up    = (ball_pos_y > 10'd225);
            btn_left_down  = !(ball_pos_y > 10'd225);
            btn_right_up   = btn_left_up;
            btn_right_down = btn_left_down;
            do_tick();
            sum = int'(score_left) + int'(score_right);
            if (sum != prev_sum) begin
                check("score step", sum, prev_sum + 1);
                prev_sum = sum;
            end
        end
        check("game_over reached", int'(game_over), 1);
        hi = (score_left > score_right) ? int'(score_left) : int'(score_right);
        lo = (score_left > score_right) ? int'(score_right) : int'(score_left);
        check("winner score", hi, 7);
        check("loser below win", int'(lo < 7), 1);
        check("over ball_x", int'(ball_pos_x), 320);
        check("over ball_y", int'(ball_pos_y), 245);

        pl0 = int'(paddle_left_pos);
        pr0 = int'(paddle_right_pos);
        sl0 = int'(score_left);
        sr0 = int'(score_right);
        btn_left_up = 1'b1;  btn_left_down = 1'b0;
        btn_right_up = 1'b0; btn_right_down = 1'b1;
        repeat (5) do_tick();
        check_all("frozen", 320, 245, pl0, pr0, sl0, sr0, 1);
        btn_left_up = 1'b0; btn_right_down = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_all("restart", 320, 245, pl0, pr0, 0, 0, 0);
        repeat (60) do_tick();
        check("restart serve held x", int'(ball_pos_x), 320);
        check("restart serve held y", int'(ball_pos_y), 245);
        do_tick();
        check("restart launch x", int'(ball_pos_x == 10'd318 || ball_pos_x == 10'd322), 1);
        check("restart launch y", int'(ball_pos_y == 10'd243 || ball_pos_y == 10'd247), 1);

        // Asynchronous reset mid-play, observed before any clock edge.
        btn_left_up = 1'b1;
        repeat (3) do_tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("async reset", 320, 245, 225, 225, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        do_tick();
        check_all("post reset", 320, 245, 222, 225, 0, 0, 0);
        btn_left_up = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
Game-state producer that drives the VGA renderer's ball and paddle position inputs. On each frame tick it moves the paddles from player buttons and advances the ball. It also resolves wall, paddle and goal collisions, keeps score and sequences serve, scored and game-over phases. Its position outputs connect directly to the renderer's position inputs and use the same geometry conventions:
- Ball occupies [x, x+BALL_SIZE] by [y, y+BALL_SIZE], inclusive.
- Left paddle occupies x in [CANVAS_LEFT+PADDLE_OFFSET, CANVAS_LEFT+PADDLE_OFFSET+PADDLE_WIDTH] = [70,80], and y in [pos, pos+PADDLE_HEIGHT].
- Right paddle occupies x in [CANVAS_RIGHT-PADDLE_OFFSET-PADDLE_WIDTH, CANVAS_RIGHT-PADDLE_OFFSET] = [570,580], and y in [pos, pos+PADDLE_HEIGHT].

Parameters:
CANVAS_TOP, 50, top border row
CANVAS_BOTTOM, 450, bottom border row
CANVAS_LEFT, 50, left border column
CANVAS_RIGHT, 600, right border column
BALL_SIZE, 10, ball extent minus one
PADDLE_OFFSET, 20, paddle inset from side border
PADDLE_HEIGHT, 50, paddle extent minus one (y)
PADDLE_WIDTH, 10, paddle extent minus one (x)
BALL_SPEED, 2, ball pixels per frame, each axis
PADDLE_SPEED, 3, paddle pixels per frame
SERVE_FRAMES, 60, frames the ball is held before launch
WIN_SCORE, 7, points that end the game

Ports:
clk  input  1  system clock (the pixel clock shared with the renderer)
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-clk pulse per frame, from the vsync edge
start  input  1  restarts the game from GAME_OVER; ignored in other states
btn_left_up, btn_left_down  input  1 each  left player buttons, already synchronous levels
btn_right_up, btn_right_down  input  1 each  right player buttons, already synchronous levels
ball_pos_x, ball_pos_y  output  10 each  ball top-left corner, registered
paddle_left_pos, paddle_right_pos  output  10 each  paddle top row, registered
score_left, score_right  output  4 each  points won, registered
game_over  output  1  high while in GAME_OVER

Behaviour:
- Reset (async, active-high) loads:
  - ball to (320,245), i.e. (L+R)/2-BALL_SIZE/2 by (T+B)/2-BALL_SIZE/2;
  - paddles to 225;
  - scores to 0, game_over=0;
  - direction x=right, direction y=down, serve counter=0, state=SERVE.
- All updates occur in the cycle where frame_tick=1. Outputs are registered and change one clk after the tick. SCORED is the only state that advances without a tick.
- Paddles:
  - Move on every tick except in GAME_OVER.
  - Up pressed alone: pos -= PADDLE_SPEED. Down pressed alone: pos += PADDLE_SPEED. Both or neither pressed: hold.
  - Clamp to [CANVAS_TOP+1, CANVAS_BOTTOM-1-PADDLE_HEIGHT] = [51,399].
  - Use 11-bit signed intermediates so no wrap-around occurs.
- State SERVE:
  - Ball is held at centre.
  - Each tick increments the counter. On the tick where the counter equals SERVE_FRAMES-1, clear the counter and go to PLAY; the ball does not move on that tick.
- State PLAY (per tick), with nx = x±BALL_SPEED and ny = y±BALL_SPEED:
  - Vertical axis:
    - Moving up and ny <= CANVAS_TOP: y = CANVAS_TOP+1, flip to down.
    - Moving down and ny+BALL_SIZE >= CANVAS_BOTTOM: y = CANVAS_BOTTOM-1-BALL_SIZE, flip to up.
    - Otherwise y = ny.
  - Overlap test: ball y range intersects paddle y range (y+BALL_SIZE >= pos and y <= pos+PADDLE_HEIGHT). Use the current tick's pre-update y and pre-update paddle position.
  - Left paddle hit: moving left, x > 80, nx <= 80, and overlap → x = 81, flip to right.
  - Right paddle hit: moving right, x+BALL_SIZE < 570, nx+BALL_SIZE >= 570, and overlap → x = 559, flip to left.
  - Goals: moving left with no hit and nx <= CANVAS_LEFT → point to right player, go to SCORED. Moving right with no hit and nx+BALL_SIZE >= CANVAS_RIGHT → point to left player, go to SCORED.
  - Otherwise x = nx.
  - The x and y axes resolve independently on the same tick; a corner case may apply a wall bounce and a paddle hit together.
- State SCORED (one clk):
  - Increment the scorer's score.
  - Set direction x toward the player who conceded; keep direction y.
  - Recentre the ball.
  - If the new score equals WIN_SCORE go to GAME_OVER, else go to SERVE.
- State GAME_OVER:
  - game_over=1; ball held at centre; paddles frozen; scores held.
  - start=1 clears the scores, sets game_over=0 and goes to SERVE on the next clk.
- Reset mid-operation returns immediately to the reset values listed above.

Decomposition:
- Package pong_pkg holds the geometry and speed constants listed above and the state encoding (SERVE, PLAY, SCORED, GAME_OVER). The renderer shares this package.
- Sub-module pong_paddle_ctrl, instantiated twice: holds a paddle register, applies button-driven movement with clamping, and has an enable input. Ball movement, collision handling and the FSM stay in the top-level module.

Test Plan:
- Reset, then 60 ticks → ball stays at (320,245). Tick 61 → ball at (322,247).
- PLAY with ball at x=82, moving left, y=245, paddle_left_pos=225 → x=81, direction right. Next tick → x=83.
- PLAY with ball at y=51, moving up → y stays 51, direction down. Next tick → y=53.
- btn_left_up held from pos 225 for 80 ticks → pos saturates at 51. Both buttons held → pos unchanged.
- PLAY with ball moving left, paddle_left_pos=51 and ball y=245 (no overlap) → score_right becomes 1 once nx <= 50, ball returns to (320,245), serve goes leftward.
- score_right=6 and another right-player point → score_right=7, game_over=1. Button presses are then ignored. start pulse → scores 0, game_over=0, state SERVE.
